pipe_ctrl: RTL and testbench

Central pipeline sequencer for the six-stage core (pc, if, id, ex, mem, wb).
- Merges stall requests from id, ex and mem into the per-stage stall vector consumed by the pc register and the pipeline registers.
- Accepts exception/eret requests from the mem stage, issues the pipeline flush and the redirect PC.
- After a flush, runs a short hold-off window in which new exception requests are masked.

---
 rtl/pipe_ctrl.sv | 114 +++++++++++
 tb/tb_pipe_ctrl.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/pipe_ctrl.sv
// pipe_ctrl: six-stage pipeline sequencer (stall merge, exception flush/redirect, post-flush hold).
// Optional stall watchdog is built when PIPE_CTRL_STALL_WDT_EN is defined.
module pipe_ctrl #(
  parameter logic [31:0] INT_VEC     = 32'h0000_0020,
  parameter logic [31:0] EXC_VEC     = 32'h0000_0040,
  parameter int unsigned HOLD_CYCLES = 2,
  parameter logic [15:0] WDT_LIMIT   = 16'd1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stallreq_id,
  input  logic        stallreq_ex,
  input  logic        stallreq_mem,
  input  logic        excp_valid,
  input  logic [4:0]  excp_code,
  input  logic [31:0] epc_i,
  output logic [5:0]  stall,
  output logic        flush,
  output logic [31:0] new_pc,
  output logic        stall_timeout
);

  localparam int unsigned HcW      = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES + 1) : 1;
  localparam logic [4:0]  CodeInt  = 5'h00;
  localparam logic [4:0]  CodeEret = 5'h0e;

  typedef enum logic [0:0] {StRun, StHold} state_e;

  state_e         r_state, w_state_d;
  logic [HcW-1:0] r_hold_cnt, w_hold_cnt_d;
  logic           w_accept;
  logic [5:0]     w_stall_req;

  always_comb begin
    if (stallreq_mem)     w_stall_req = 6'b011111;
    else if (stallreq_ex) w_stall_req = 6'b001111;
    else if (stallreq_id) w_stall_req = 6'b000111;
    else                  w_stall_req = 6'b000000;
  end

  // A bus-waiting mem stage keeps its exception pending until the wait ends.
  assign w_accept = (r_state == StRun) && excp_valid && !stallreq_mem;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= StRun;
      r_hold_cnt <= '0;
    end else begin
      r_state    <= w_state_d;
      r_hold_cnt <= w_hold_cnt_d;
    end
  end

  always_comb begin
    w_state_d    = r_state;
    w_hold_cnt_d = r_hold_cnt;
    unique case (r_state)
      StRun: begin
        if (w_accept && (HOLD_CYCLES != 0)) begin
          w_state_d    = StHold;
          w_hold_cnt_d = HcW'(HOLD_CYCLES);
        end
      end
      StHold: begin
        if (r_hold_cnt <= HcW'(1)) begin
          w_state_d    = StRun;
          w_hold_cnt_d = '0;
        end else begin
          w_hold_cnt_d = r_hold_cnt - HcW'(1);
        end
      end
      default: w_state_d = StRun;
    endcase
  end

  always_comb begin
    stall  = 6'b0;
    flush  = 1'b0;
    new_pc = 32'h0;
    if (!rst) begin
      if (w_accept) begin
        flush = 1'b1;
        if (excp_code == CodeEret)     new_pc = epc_i;
        else if (excp_code == CodeInt) new_pc = INT_VEC;
        else                           new_pc = EXC_VEC;
      end else begin
        stall = w_stall_req;
      end
    end
  end

`ifdef PIPE_CTRL_STALL_WDT_EN
  logic [15:0] r_wdt_cnt;
  logic        w_wdt_hit;

  assign w_wdt_hit     = (r_wdt_cnt == WDT_LIMIT - 16'd1);
  assign stall_timeout = !rst && (stall != 6'b0) && w_wdt_hit;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wdt_cnt <= 16'd0;
    end else if ((stall == 6'b0) || flush || w_wdt_hit) begin
      r_wdt_cnt <= 16'd0;
    end else begin
      r_wdt_cnt <= r_wdt_cnt + 16'd1;
    end
  end
`else
  logic w_unused_wdt;
  assign w_unused_wdt  = ^WDT_LIMIT;
  assign stall_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// Bench for pipe_ctrl: directed vector table, reset/watchdog sequences, random run vs. model.
module tb_pipe_ctrl;

`ifdef PIPE_CTRL_STALL_WDT_EN
  localparam logic [15:0] TbWdt = 16'd8;
`else
  localparam logic [15:0] TbWdt = 16'd1024;
`endif
  localparam int unsigned TbHold = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stallreq_id = 1'b0, stallreq_ex = 1'b0, stallreq_mem = 1'b0;
  logic        excp_valid = 1'b0;
  logic [4:0]  excp_code = 5'h0;
  logic [31:0] epc_i = 32'h0;
  logic [5:0]  stall;
  logic        flush;
  logic [31:0] new_pc;
  logic        stall_timeout;

  int checks = 0;
  int errors = 0;

  // Model state: remaining masked cycles and length of the current stall run.
  int m_hold = 0;
  int m_run  = 0;

  pipe_ctrl #(
    .INT_VEC    (32'h0000_0020),
    .EXC_VEC    (32'h0000_0040),
    .HOLD_CYCLES(TbHold),
    .WDT_LIMIT  (TbWdt)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .stallreq_id  (stallreq_id),
    .stallreq_ex  (stallreq_ex),
    .stallreq_mem (stallreq_mem),
    .excp_valid   (excp_valid),
    .excp_code    (excp_code),
    .epc_i        (epc_i),
    .stall        (stall),
    .flush        (flush),
    .new_pc       (new_pc),
    .stall_timeout(stall_timeout)
  );

  always #5 clk = ~clk;

  initial begin
    #1ms;
    $display("FAIL global_timeout act=running exp=finished");
    $fatal(1);
  end

  typedef struct {
    logic        id, ex, mem, ev;
    logic [4:0]  code;
    logic [31:0] epc;
    logic [5:0]  stall;
    logic        flush;
    logic [31:0] pc;
  } vec_t;

  vec_t tbl[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%h exp=%h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock cycle: drive, predict, compare (table values when has_exp), advance model.
  task automatic step(input logic id, ex, mem, ev, input logic [4:0] code,
                      input logic [31:0] epc, input bit has_exp, input logic [5:0] t_stall,
                      input logic t_flush, input logic [31:0] t_pc, input logic t_to,
                      input string tag);
    logic [5:0]  m_stall;
    logic        m_flush;
    logic [31:0] m_pc;
    logic        m_to;
    bit          acc;
    @(posedge clk);
    #1;
    stallreq_id = id; stallreq_ex = ex; stallreq_mem = mem;
    excp_valid = ev; excp_code = code; epc_i = epc;
    m_stall = mem ? 6'h1f : ex ? 6'h0f : id ? 6'h07 : 6'h00;
    m_flush = 1'b0;
    m_pc    = 32'h0;
    acc     = (m_hold == 0) && ev && !mem;
    if (acc) begin
      m_flush = 1'b1;
      m_stall = 6'h00;
      m_pc    = (code == 5'h0e) ? epc : (code == 5'h00) ? 32'h20 : 32'h40;
    end
`ifdef PIPE_CTRL_STALL_WDT_EN
    m_to = (m_stall != 6'h00) && (((m_run + 1) % int'(TbWdt)) == 0);
`else
    m_to = 1'b0;
`endif
    if (has_exp) begin
      m_stall = t_stall; m_flush = t_flush; m_pc = t_pc; m_to = t_to;
    end
    #3;
    chk({tag, "_stall"}, 32'(stall), 32'(m_stall));
    chk({tag, "_flush"}, 32'(flush), 32'(m_flush));
    chk({tag, "_pc"}, new_pc, m_pc);
    chk({tag, "_timeout"}, 32'(stall_timeout), 32'(m_to));
    if (acc) m_hold = TbHold;
    else if (m_hold > 0) m_hold--;
    m_run = ((mem || ex || id) && !acc) ? m_run + 1 : 0;
  endtask

  task automatic idle(input string tag);
    step(1'b0, 1'b0, 1'b0, 1'b0, 5'h0, 32'h0, 1'b0, 6'h0, 1'b0, 32'h0, 1'b0, tag);
  endtask

  initial begin
    logic [4:0] rc;
    tbl.push_back('{1'b1, 1'b0, 1'b0, 1'b0, 5'h00, 32'h0, 6'h07, 1'b0, 32'h0});
    tbl.push_back('{1'b1, 1'b1, 1'b0, 1'b0, 5'h00, 32'h0, 6'h0f, 1'b0, 32'h0});
    tbl.push_back('{1'b1, 1'b1, 1'b1, 1'b0, 5'h00, 32'h0, 6'h1f, 1'b0, 32'h0});
    tbl.push_back('{1'b0, 1'b0, 1'b0, 1'b0, 5'h00, 32'h0, 6'h00, 1'b0, 32'h0});
    tbl.push_back('{1'b0, 1'b0, 1'b0, 1'b1, 5'h0c, 32'h0, 6'h00, 1'b1, 32'h40});
    tbl.push_back('{1'b0, 1'b0, 1'b0, 1'b1, 5'h0c, 32'h0, 6'h00, 1'b0, 32'h0});
    tbl.push_back('{1'b0, 1'b0, 1'b0, 1'b1, 5'h0c, 32'h0, 6'h00, 1'b0, 32'h0});
    tbl.push_back('{1'b0, 1'b0, 1'b0, 1'b1, 5'h0c, 32'h0, 6'h00, 1'b1, 32'h40});
    tbl.push_back('{1'b0, 1'b0, 1'b0, 1'b0, 5'h00, 32'h0, 6'h00, 1'b0, 32'h0});
    tbl.push_back('{1'b1, 1'b0, 1'b0, 1'b0, 5'h00, 32'h0, 6'h07, 1'b0, 32'h0});
    tbl.push_back('{1'b0, 1'b0, 1'b0, 1'b1, 5'h0e, 32'h1234, 6'h00, 1'b1, 32'h1234});
    tbl.push_back('{1'b0, 1'b0, 1'b0, 1'b0, 5'h00, 32'h0, 6'h00, 1'b0, 32'h0});
    tbl.push_back('{1'b0, 1'b0, 1'b0, 1'b0, 5'h00, 32'h0, 6'h00, 1'b0, 32'h0});
    tbl.push_back('{1'b0, 1'b0, 1'b0, 1'b1, 5'h00, 32'h0, 6'h00, 1'b1, 32'h20});
    tbl.push_back('{1'b0, 1'b0, 1'b0, 1'b0, 5'h00, 32'h0, 6'h00, 1'b0, 32'h0});
    tbl.push_back('{1'b0, 1'b0, 1'b0, 1'b0, 5'h00, 32'h0, 6'h00, 1'b0, 32'h0});
    for (int i = 0; i < 4; i++)
      tbl.push_back('{1'b0, 1'b0, 1'b1, 1'b1, 5'h0c, 32'h0, 6'h1f, 1'b0, 32'h0});
    tbl.push_back('{1'b0, 1'b0, 1'b0, 1'b1, 5'h0c, 32'h0, 6'h00, 1'b1, 32'h40});
    tbl.push_back('{1'b0, 1'b1, 1'b0, 1'b1, 5'h0c, 32'h0, 6'h0f, 1'b0, 32'h0});
    tbl.push_back('{1'b0, 1'b0, 1'b0, 1'b1, 5'h0c, 32'h0, 6'h00, 1'b0, 32'h0});
    tbl.push_back('{1'b0, 1'b0, 1'b0, 1'b0, 5'h00, 32'h0, 6'h00, 1'b0, 32'h0});
    tbl.push_back('{1'b1, 1'b1, 1'b0, 1'b1, 5'h03, 32'h0, 6'h00, 1'b1, 32'h40});
    tbl.push_back('{1'b0, 1'b0, 1'b0, 1'b0, 5'h00, 32'h0, 6'h00, 1'b0, 32'h0});
    tbl.push_back('{1'b0, 1'b0, 1'b0, 1'b0, 5'h00, 32'h0, 6'h00, 1'b0, 32'h0});

    // Outputs forced low during reset even with requests present.
    stallreq_mem = 1'b1; excp_valid = 1'b1;
    #2;
    chk("reset_stall", 32'(stall), 32'h0);
    chk("reset_flush", 32'(flush), 32'h0);
    chk("reset_pc", new_pc, 32'h0);
    chk("reset_timeout", 32'(stall_timeout), 32'h0);
    stallreq_mem = 1'b0; excp_valid = 1'b0;
    @(posedge clk);
    #1 rst = 1'b0;

    foreach (tbl[i])
      step(tbl[i].id, tbl[i].ex, tbl[i].mem, tbl[i].ev, tbl[i].code, tbl[i].epc, 1'b1,
           tbl[i].stall, tbl[i].flush, tbl[i].pc, 1'b0, $sformatf("vec%0d", i));

    // Async reset in the middle of the HOLD window.
    step(1'b0, 1'b0, 1'b0, 1'b1, 5'h0c, 32'h0, 1'b1, 6'h00, 1'b1, 32'h40, 1'b0, "rst_pre");
    @(posedge clk);
    #1 stallreq_mem = 1'b1; excp_valid = 1'b0;
    #1 rst = 1'b1;
    #1;
    chk("rst_mid_stall", 32'(stall), 32'h0);
    chk("rst_mid_flush", 32'(flush), 32'h0);
    @(posedge clk);
    #2 rst = 1'b0; stallreq_mem = 1'b0; excp_valid = 1'b1; excp_code = 5'h0c;
    #1;
    chk("rst_post_flush", 32'(flush), 32'h1);
    chk("rst_post_pc", new_pc, 32'h40);
    m_hold = TbHold;
    m_run  = 0;
    idle("rst_h1");
    idle("rst_h2");

`ifdef PIPE_CTRL_STALL_WDT_EN
    idle("wdt_pre");
    for (int i = 1; i <= 20; i++)
      step(1'b0, 1'b1, 1'b0, 1'b0, 5'h0, 32'h0, 1'b1, 6'h0f, 1'b0, 32'h0,
           ((i == 8) || (i == 16)), $sformatf("wdt%0d", i));
    idle("wdt_post");
`endif

    for (int i = 0; i < 400; i++) begin
      case ($urandom_range(0, 2))
        0:       rc = 5'h00;
        1:       rc = 5'h0e;
        default: rc = 5'($urandom_range(1, 31));
      endcase
      step(($urandom % 4) == 0, ($urandom % 4) == 0, ($urandom % 5) == 0,
           ($urandom % 3) == 0, rc, $urandom, 1'b0, 6'h0, 1'b0, 32'h0, 1'b0, "rnd");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
